// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the R-format ALU control sequencer: the sequencer
// state encoding, the R-format opcode map, the instruction-register field
// positions and the default highest legal opcode.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6
  } state_e;

  // R-format opcode map; the ALU consumes these values directly.
  typedef enum logic [4:0] {
    OPC_ADD = 5'd0,
    OPC_SUB = 5'd1,
    OPC_SHR = 5'd2,
    OPC_SHL = 5'd3,
    OPC_ROR = 5'd4,
    OPC_AND = 5'd5,
    OPC_OR  = 5'd6,
    OPC_ROL = 5'd7,
    OPC_MUL = 5'd8,
    OPC_DIV = 5'd9,
    OPC_NEG = 5'd10,
    OPC_SRA = 5'd11,
    OPC_NOT = 5'd12
  } opcode_e;

  localparam logic [4:0] OPC_MAX = OPC_NOT;

  // Instruction register field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

endpackage

// File: rtl/dec4to16.sv
// dec4to16
// 4-to-16 one-hot decoder with enable. Output is all zeros when disabled.
// Ports:
//   en   in   1   decoder enable
//   idx  in   4   index of the bit to set
//   y    out  16  one-hot result
module dec4to16 (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer
// Hardwired control unit for R-format ALU instructions. Runs the fetch
// sequence (T0-T2), decodes IR in T3 and runs the execute sequence (T3-T5),
// producing the datapath strobes each cycle.
// Ports:
//   Clock, Resetn          system clock (rising edge), async active-low reset
//   Run                    keep fetching/executing while high
//   MemReady               memory has valid data this cycle (T1 handshake)
//   IR [31:0]              instruction register fed back from the datapath
//   PCout/ZLOout/MDRout    bus-source selects
//   MARin/PCin/MDRin/IRin/Yin/Zin   register load enables
//   IncrementPC, Read      ALU PC+1, memory read request
//   ALUControl [4:0]       ALU operation (opcode in T4, else 0)
//   Rout/Rin [NUM_REGS]    one-hot general-register bus drive / load
//   Done, Illegal          one-cycle retire / reject pulses
//
// state | meaning
// IDLE  | waiting for Run
// T0    | PC to MAR, start PC+1 into Z
// T1    | memory read; waits here while MemReady is low, loads PC on ready
// T2    | MDR to IR
// T3    | decode; Rb into Y, or reject an illegal opcode
// T4    | Rc on bus, ALU op into Z
// T5    | Z into Ra, retire
module alu_control_sequencer #(
  parameter int         NUM_REGS = 16,
  parameter logic [4:0] OPC_MAX  = cpu_ctrl_pkg::OPC_MAX
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic                MemReady,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                ZLOout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                IncrementPC,
  output logic                Read,
  output logic [4:0]          ALUControl,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Done,
  output logic                Illegal
);

  import cpu_ctrl_pkg::*;

  state_e state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        opc_illegal;
  logic        rout_en, rin_en;
  logic [3:0]  rout_idx;
  logic [15:0] rout_dec, rin_dec;
  logic        unused_ir;

  assign opcode      = IR[OPC_MSB:OPC_LSB];
  assign ra          = IR[RA_MSB:RA_LSB];
  assign rb          = IR[RB_MSB:RB_LSB];
  assign rc          = IR[RC_MSB:RC_LSB];
  assign opc_illegal = (opcode > OPC_MAX);
  assign unused_ir   = ^IR[RC_LSB-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCout       = 1'b0;
    ZLOout      = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    IncrementPC = 1'b0;
    Read        = 1'b0;
    ALUControl  = 5'd0;
    Done        = 1'b0;
    Illegal     = 1'b0;
    rout_en     = 1'b0;
    rout_idx    = rb;
    rin_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_T0;
      end
      ST_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        IncrementPC = 1'b1;
        Zin         = 1'b1;
        state_d     = ST_T1;
      end
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // PC+1 sitting in Z is written back only on the cycle the read completes
        if (MemReady) begin
          ZLOout  = 1'b1;
          PCin    = 1'b1;
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        if (opc_illegal) begin
          Illegal = 1'b1;
          state_d = Run ? ST_T0 : ST_IDLE;
        end else begin
          rout_en  = 1'b1;
          rout_idx = rb;
          Yin      = 1'b1;
          state_d  = ST_T4;
        end
      end
      ST_T4: begin
        rout_en    = 1'b1;
        rout_idx   = rc;
        ALUControl = opcode;
        Zin        = 1'b1;
        state_d    = ST_T5;
      end
      ST_T5: begin
        ZLOout  = 1'b1;
        rin_en  = 1'b1;
        Done    = 1'b1;
        state_d = Run ? ST_T0 : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dec4to16 u_rout_dec (
    .en  (rout_en),
    .idx (rout_idx),
    .y   (rout_dec)
  );

  dec4to16 u_rin_dec (
    .en  (rin_en),
    .idx (ra),
    .y   (rin_dec)
  );

  assign Rout = rout_dec[NUM_REGS-1:0];
  assign Rin  = rin_dec[NUM_REGS-1:0];

endmodule

// File: tb/tb_alu_control_sequencer.sv
module tb_alu_control_sequencer;

  logic        Clock, Resetn, Run, MemReady;
  logic [31:0] IR;
  logic        PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic        IncrementPC, Read, Done, Illegal;
  logic [4:0]  ALUControl;
  logic [15:0] Rout, Rin;

  int errors = 0;
  int checks = 0;

  // {PCout,ZLOout,MDRout,MARin,PCin,MDRin,IRin,Yin,Zin,IncrementPC,Read,Done,Illegal}
  localparam logic [12:0] S_NONE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] S_T0   = 13'b1_0_0_1_0_0_0_0_1_1_0_0_0;
  localparam logic [12:0] S_T1W  = 13'b0_0_0_0_0_1_0_0_0_0_1_0_0;
  localparam logic [12:0] S_T1R  = 13'b0_1_0_0_1_1_0_0_0_0_1_0_0;
  localparam logic [12:0] S_T2   = 13'b0_0_1_0_0_0_1_0_0_0_0_0_0;
  localparam logic [12:0] S_T3   = 13'b0_0_0_0_0_0_0_1_0_0_0_0_0;
  localparam logic [12:0] S_T3I  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] S_T4   = 13'b0_0_0_0_0_0_0_0_1_0_0_0_0;
  localparam logic [12:0] S_T5   = 13'b0_1_0_0_0_0_0_0_0_0_0_1_0;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_W    = {5'd12, 4'd4, 4'd5, 4'd6, 15'd0};
  localparam logic [31:0] IR_I31  = {5'd31, 4'd7, 4'd7, 4'd7, 15'd0};
  localparam logic [31:0] IR_I13  = {5'd13, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_A0   = {5'd0, 4'd0, 4'd0, 4'd0, 15'd0};
  localparam logic [31:0] IR_A1   = {5'd0, 4'd15, 4'd14, 4'd13, 15'd0};

  alu_control_sequencer #(.NUM_REGS(16), .OPC_MAX(5'd12)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Run         (Run),
    .MemReady    (MemReady),
    .IR          (IR),
    .PCout       (PCout),
    .ZLOout      (ZLOout),
    .MDRout      (MDRout),
    .MARin       (MARin),
    .PCin        (PCin),
    .MDRin       (MDRin),
    .IRin        (IRin),
    .Yin         (Yin),
    .Zin         (Zin),
    .IncrementPC (IncrementPC),
    .Read        (Read),
    .ALUControl  (ALUControl),
    .Rout        (Rout),
    .Rin         (Rin),
    .Done        (Done),
    .Illegal     (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] ectl, input logic [4:0] ealu,
                     input logic [15:0] erout, input logic [15:0] erin);
    logic [12:0] actl;
    int nsrc;
    #1;
    actl = {PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
            IncrementPC, Read, Done, Illegal};
    checks++;
    assert (actl === ectl) else begin
      errors++;
      $error("FAIL %s strobes: got %b expected %b", tag, actl, ectl);
    end
    checks++;
    assert (ALUControl === ealu) else begin
      errors++;
      $error("FAIL %s ALUControl: got %h expected %h", tag, ALUControl, ealu);
    end
    checks++;
    assert (Rout === erout) else begin
      errors++;
      $error("FAIL %s Rout: got %h expected %h", tag, Rout, erout);
    end
    checks++;
    assert (Rin === erin) else begin
      errors++;
      $error("FAIL %s Rin: got %h expected %h", tag, Rin, erin);
    end
    nsrc = int'(PCout) + int'(ZLOout) + int'(MDRout) + $countones(Rout);
    checks++;
    assert (nsrc <= 1) else begin
      errors++;
      $error("FAIL %s bus_sources: got %0d expected at most 1", tag, nsrc);
    end
  endtask

  initial begin
    Resetn   = 1'b0;
    Run      = 1'b1;
    MemReady = 1'b1;
    IR       = 32'h0;

    // reset held with Run high
    #12;
    chk("reset", S_NONE, 5'd0, 16'h0, 16'h0);
    step(); step();
    chk("reset_clk", S_NONE, 5'd0, 16'h0, 16'h0);
    Resetn = 1'b1;
    chk("idle_release", S_NONE, 5'd0, 16'h0, 16'h0);

    // AND R1 = R2 & R3, zero-wait memory
    step(); chk("and_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("and_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_AND; chk("and_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("and_t3", S_T3, 5'd0, 16'h0004, 16'h0);
    step(); chk("and_t4", S_T4, 5'b00101, 16'h0008, 16'h0);
    step(); chk("and_t5", S_T5, 5'd0, 16'h0, 16'h0002);

    // opcode 12 (highest legal) with three memory wait cycles
    step(); MemReady = 1'b0; chk("w_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("w_t1_1", S_T1W, 5'd0, 16'h0, 16'h0);
    step(); chk("w_t1_2", S_T1W, 5'd0, 16'h0, 16'h0);
    step(); chk("w_t1_3", S_T1W, 5'd0, 16'h0, 16'h0);
    step(); MemReady = 1'b1; chk("w_t1_4", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_W; chk("w_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("w_t3", S_T3, 5'd0, 16'h0020, 16'h0);
    step(); chk("w_t4", S_T4, 5'd12, 16'h0040, 16'h0);
    step(); chk("w_t5", S_T5, 5'd0, 16'h0, 16'h0010);

    // illegal opcode 31, Run high -> straight back to T0
    step(); chk("i31_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("i31_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_I31; chk("i31_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("i31_t3", S_T3I, 5'd0, 16'h0, 16'h0);
    step(); chk("i31_next", S_T0, 5'd0, 16'h0, 16'h0);

    // illegal opcode 13 (one above the highest legal)
    step(); chk("i13_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_I13; chk("i13_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("i13_t3", S_T3I, 5'd0, 16'h0, 16'h0);

    // back-to-back ADDs: R0 = R0 + R0, then R15 = R14 + R13
    step(); chk("b1_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("b1_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_A0; chk("b1_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("b1_t3", S_T3, 5'd0, 16'h0001, 16'h0);
    step(); chk("b1_t4", S_T4, 5'd0, 16'h0001, 16'h0);
    step(); chk("b1_t5", S_T5, 5'd0, 16'h0, 16'h0001);
    step(); chk("b2_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("b2_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_A1; chk("b2_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("b2_t3", S_T3, 5'd0, 16'h4000, 16'h0);
    step(); Run = 1'b0; chk("b2_t4", S_T4, 5'd0, 16'h2000, 16'h0);
    step(); chk("b2_t5", S_T5, 5'd0, 16'h0, 16'h8000);
    step(); chk("b2_idle", S_NONE, 5'd0, 16'h0, 16'h0);
    step(); chk("b2_idle2", S_NONE, 5'd0, 16'h0, 16'h0);

    // async reset in T4
    Run = 1'b1;
    step(); chk("r_t0", S_T0, 5'd0, 16'h0, 16'h0);
    step(); chk("r_t1", S_T1R, 5'd0, 16'h0, 16'h0);
    step(); IR = IR_AND; chk("r_t2", S_T2, 5'd0, 16'h0, 16'h0);
    step(); chk("r_t3", S_T3, 5'd0, 16'h0004, 16'h0);
    step(); chk("r_t4", S_T4, 5'b00101, 16'h0008, 16'h0);
    #2;
    Resetn = 1'b0;
    chk("r_async", S_NONE, 5'd0, 16'h0, 16'h0);
    step(); chk("r_held", S_NONE, 5'd0, 16'h0, 16'h0);
    Run = 1'b0;
    Resetn = 1'b1;
    step(); chk("r_idle", S_NONE, 5'd0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Hardwired control unit for R-format ALU instructions. It produces, cycle by cycle, the datapath control strobes that the `phase1` datapath consumes: bus-source selects, register load enables, ALU operation, and memory read. It runs the fetch sequence T0–T2, decodes IR, and runs the execute sequence T3–T5. It sits between the instruction memory handshake and the datapath, and replaces hand-driven stimulus.

## Interface
Parameters:
- `NUM_REGS`, 16: general registers; sets the width of the one-hot `Rout`/`Rin`.
- `OPC_MAX`, 5'd12: highest legal R-format opcode; opcodes above it are illegal.

Ports:
- `Clock`  in  1  single system clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Run`  in  1  level; while high, the sequencer keeps fetching and executing.
- `MemReady`  in  1  memory has valid `Mdatain` this cycle.
- `IR`  in  32  instruction register contents, fed back from the datapath.
- `PCout`, `ZLOout`, `MDRout`  out  1 each  bus-source selects.
- `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `Zin`  out  1 each  register load enables.
- `IncrementPC`  out  1  ALU computes PC+1.
- `Read`  out  1  memory read request.
- `ALUControl`  out  5  ALU operation code.
- `Rout`  out  NUM_REGS  one-hot general-register bus drive.
- `Rin`  out  NUM_REGS  one-hot general-register load.
- `Done`  out  1  one-cycle pulse when an instruction retires.
- `Illegal`  out  1  one-cycle pulse when an opcode is rejected.

## Operation
- Instruction fields: opcode = IR[31:27], Ra (destination) = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- For a legal opcode, `ALUControl` = opcode in T4 and 5'b0 in every other state.
- States and asserted outputs (every output not listed is 0):
  - IDLE: none. Moves to T0 when `Run`=1.
  - T0: `PCout`, `MARin`, `IncrementPC`, `Zin`. Always moves to T1.
  - T1: `Read`, `MDRin`. While `MemReady`=0 it stays in T1, holding `Read`/`MDRin`. When `MemReady`=1 it additionally asserts `ZLOout` and `PCin`, and moves to T2.
  - T2: `MDRout`, `IRin`. Always moves to T3.
  - T3: if opcode > `OPC_MAX`: no strobes, `Illegal`=1, then go to T0 if `Run`, else IDLE. Otherwise: `Rout[Rb]`, `Yin`, then go to T4.
  - T4: `Rout[Rc]`, `ALUControl`=opcode, `Zin`. Moves to T5.
  - T5: `ZLOout`, `Rin[Ra]`, `Done`=1. Goes to T0 if `Run`=1, else IDLE.
- The T3 decode uses the IR loaded at the end of T2.
- At most one bus-source select is high in any state. This covers `PCout`, `ZLOout`, `MDRout`, and every bit of `Rout`.
- Ra = Rb = Rc is legal, with no special case. R0 is an ordinary register.
- `Run` dropping mid-instruction does not abort it. It is sampled only at T5 and at the T3 illegal exit.

## Timing
- Moore machine with a registered state. Outputs decode from the state and `IR`, except that `ZLOout`/`PCin` in T1 also depend on `MemReady`.
- Reset (async, `Resetn`=0): state goes to IDLE immediately. All outputs are 0, including `ALUControl`=0, `Rout`=0, `Rin`=0, `Done`=0, `Illegal`=0.
- Reset mid-instruction abandons the instruction and produces no `Done`. The first state after release is IDLE.
- Latency with zero-wait memory (`MemReady` high in T1): 6 cycles from T0 to `Done`.
- Each cycle `MemReady` is low in T1 adds one cycle.
- Back-to-back: T5 leads directly to T0 with no IDLE bubble.
- Illegal opcode: 4 cycles (T0–T3). Registers are untouched and no `Rin` bit is asserted.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum: IDLE, T0–T5;
  - opcode constants: ADD=0 … AND=5 … NOT=12;
  - the IR field bit positions;
  - `OPC_MAX`.
- Sub-module `dec4to16`: a 4-to-16 one-hot decoder with an enable input, instantiated twice (for `Rout` and `Rin`). The T3/T4 logic selects the Rb or Rc index into the `Rout` decoder.

## Test plan
- Reset: hold `Resetn`=0 with `Run`=1 → all outputs 0 and state IDLE. Release → T0 strobes are asserted on the next cycle.
- AND, zero-wait: IR=32'h28918000 (opcode 5, Ra=1, Rb=2, Rc=3), `MemReady`=1 → expected sequence:
  - T3: `Rout`=16'h0004.
  - T4: `Rout`=16'h0008 and `ALUControl`=5'b00101.
  - T5: `Rin`=16'h0002 and `Done` pulse.
  - Total 6 cycles; no cycle has two bus sources high.
- Memory wait: `MemReady` held low for 3 cycles in T1 → `Read`/`MDRin` stay high for 4 cycles. `PCin` is asserted only in the final T1 cycle. `Done` arrives at cycle 9.
- Illegal: IR opcode 5'd31 → `Illegal` pulses in T3. `Rin` never goes nonzero and there is no `Done`. With `Run`=1, the next cycle is T0.
- Back-to-back: two ADD instructions with `Run` held high → the second T0 immediately follows the first T5. `Run` dropped during the second T4 → that instruction still completes, then IDLE.
- Async reset in T4 → outputs clear immediately, independent of `Clock`. No `Done` is produced.
